// File: rtl/ex_hazard_controller_pkg.sv
// Shared definitions for the execute-stage hazard controller:
// forwarding-mux select codes and the sequencing FSM state encoding.
package ex_hazard_controller_pkg;

  // Operand mux select codes; 2'b11 is never driven.
  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // RUN: normal issue. MC_BUSY: a multicycle op owns the EX stage.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_e;

  // True when a producer stage writes a non-zero register matching src.
  function automatic logic reg_match(input logic [4:0] src,
                                     input logic [4:0] rd,
                                     input logic       wr_en);
    return wr_en && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/ex_hazard_controller_fwd_select.sv
// Forwarding select for one ALU operand. The younger producer (EX/MEM)
// always wins over the older one (MEM/WB); register 0 never forwards.
module fwd_select
  import ex_hazard_controller_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] ex_mem_rd_i,
  input  logic       ex_mem_reg_write_i,
  input  logic [4:0] mem_wb_rd_i,
  input  logic       mem_wb_reg_write_i,
  output logic [1:0] sel_o
);

  // Priority select: EX/MEM, then MEM/WB, else the ID/EX register value.
  always_comb begin
    sel_o = FWD_IDEX;
    if (reg_match(src_i, ex_mem_rd_i, ex_mem_reg_write_i)) begin
      sel_o = FWD_EXMEM;
    end else if (reg_match(src_i, mem_wb_rd_i, mem_wb_reg_write_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard controller: operand forwarding selects, load-use
// stall with ID/EX bubble, multicycle-op freeze, and a saturating counter
// of cycles in which the PC was held.
//
// Pipeline contract: a stage register loads only when its write enable is
// 1; a bubble input of 1 replaces the loaded control bits with zeros. There
// is no back-pressure beyond these enables.
module ex_hazard_controller
  import ex_hazard_controller_pkg::*;
#(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic [4:0]       id_ex_rs,
  input  logic [4:0]       id_ex_rt,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_mc_start,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_reg_write,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_reg_write,
  output logic [1:0]       forward_a_sel,
  output logic [1:0]       forward_b_sel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             dbg_state
);

  // The start cycle and the final (done) cycle are not counted by mc_cnt.
  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 2);

  state_e           state_q, state_d;
  logic [3:0]       mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;

  fwd_select u_fwd_a (
    .src_i              (id_ex_rs),
    .ex_mem_rd_i        (ex_mem_rd),
    .ex_mem_reg_write_i (ex_mem_reg_write),
    .mem_wb_rd_i        (mem_wb_rd),
    .mem_wb_reg_write_i (mem_wb_reg_write),
    .sel_o              (forward_a_sel)
  );

  fwd_select u_fwd_b (
    .src_i              (id_ex_rt),
    .ex_mem_rd_i        (ex_mem_rd),
    .ex_mem_reg_write_i (ex_mem_reg_write),
    .mem_wb_rd_i        (mem_wb_rd),
    .mem_wb_reg_write_i (mem_wb_reg_write),
    .sel_o              (forward_b_sel)
  );

  // Load in ID/EX whose destination feeds the instruction behind it.
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  end

  // FSM and multicycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      mc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Next state and pipeline controls; reset forces the default outputs
  // immediately since the register reset alone would leave mc_start visible.
  always_comb begin
    state_d       = state_q;
    mc_cnt_d      = mc_cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_busy       = 1'b0;
    mc_done       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          if (id_ex_mc_start) begin
            // Multicycle op wins over a simultaneous load indication.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mc_busy       = 1'b1;
            mc_cnt_d      = MC_LOAD;
            state_d       = ST_MC_BUSY;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          mc_busy = 1'b1;
          if (mc_cnt_q != 4'd0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mc_cnt_d      = mc_cnt_q - 4'd1;
          end else begin
            // Result advances; mc_start is ignored so the op cannot restart here.
            mc_done = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Bench for ex_hazard_controller: directed scenarios followed by random
// traffic. The driver pushes the expected output vector for each cycle into
// a queue; a monitor on the falling edge pops and compares it. A second DUT
// with a 2-bit counter exercises stall_cycles saturation.
module tb_ex_hazard_controller;

  localparam int MC = 4;
  localparam int W  = 45;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
  logic        id_ex_mem_read, id_ex_mc_start, ex_mem_reg_write, mem_wb_reg_write;
  logic [1:0]  forward_a_sel, forward_b_sel, fa_s, fb_s;
  logic        pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
  logic        mc_busy, mc_done, dbg_state;
  logic        pcw_s, ifw_s, idw_s, idb_s, exb_s, busy_s, done_s, dbg_s;
  logic [31:0] stall_cycles;
  logic [1:0]  stall_small;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state: age of the multicycle op in cycles (-1 = none).
  int          m_age;
  logic [31:0] m_stall;
  int          m_stall2;

  always #5 clk = ~clk;

  ex_hazard_controller #(.MC_CYCLES(MC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mc_start(id_ex_mc_start),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_cycles(stall_cycles),
    .dbg_state(dbg_state)
  );

  ex_hazard_controller #(.MC_CYCLES(MC), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mc_start(id_ex_mc_start),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .forward_a_sel(fa_s), .forward_b_sel(fb_s),
    .pc_write(pcw_s), .if_id_write(ifw_s), .id_ex_write(idw_s),
    .id_ex_bubble(idb_s), .ex_mem_bubble(exb_s),
    .mc_busy(busy_s), .mc_done(done_s), .stall_cycles(stall_small),
    .dbg_state(dbg_s)
  );

  function automatic logic [1:0] fwd_ref(input logic [4:0] src);
    if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b01;
    if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  // Drive one cycle: predict outputs, queue them, advance the model.
  task automatic step();
    logic pcw, ifw, idw, idb, exb, busy, done;
    if (reset) begin
      m_age = -1; m_stall = 0; m_stall2 = 0;
    end
    {pcw, ifw, idw, idb, exb, busy, done} = 7'b1110000;
    if (!reset) begin
      if (m_age >= 0 || id_ex_mc_start) begin
        // Inside an op (or starting one): MC-1 frozen cycles, then done.
        busy = 1'b1;
        if (m_age < 0 || m_age < MC - 1) begin
          pcw = 0; ifw = 0; idw = 0; exb = 1;
        end else begin
          done = 1'b1;
        end
      end else if (id_ex_mem_read && id_ex_rt != 0 &&
                   (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt)) begin
        pcw = 0; ifw = 0; idb = 1;
      end
    end
    exp_q.push_back({fwd_ref(id_ex_rs), fwd_ref(id_ex_rt), pcw, ifw, idw, idb,
                     exb, busy, done, m_stall, 2'(m_stall2)});
    @(posedge clk);
    if (!reset) begin
      if (!pcw) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (m_stall2 != 3) m_stall2 = m_stall2 + 1;
      end
      if (m_age >= 0) begin
        m_age = m_age + 1;
        if (m_age == MC) m_age = -1;
      end else if (id_ex_mc_start) begin
        m_age = 1;
      end
    end
    cyc = cyc + 1;
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0;
    if_id_rs = 0; if_id_rt = 0; id_ex_rs = 0; id_ex_rt = 0;
    ex_mem_rd = 0; mem_wb_rd = 0;
    id_ex_mem_read = 0; id_ex_mc_start = 0;
    ex_mem_reg_write = 0; mem_wb_reg_write = 0;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    logic [W-1:0] e, got;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = {forward_a_sel, forward_b_sel, pc_write, if_id_write, id_ex_write,
             id_ex_bubble, ex_mem_bubble, mc_busy, mc_done, stall_cycles,
             stall_small};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, got, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    m_age = -1; m_stall = 0; m_stall2 = 0;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    step(); step();
    reset = 0;
    step();

    // Forwarding priority: EX/MEM over MEM/WB, then MEM/WB when rd=0.
    ex_mem_rd = 5; ex_mem_reg_write = 1; mem_wb_rd = 5; mem_wb_reg_write = 1;
    id_ex_rs = 5; id_ex_rt = 5;
    step();
    ex_mem_rd = 0;
    step();
    idle_inputs();

    // Load-use stall, then load moves on; then rt=0 gives no stall.
    id_ex_mem_read = 1; id_ex_rt = 8; if_id_rs = 8;
    step();
    id_ex_mem_read = 0; id_ex_rt = 0;
    step();
    id_ex_mem_read = 1; id_ex_rt = 0; if_id_rs = 0;
    step();
    idle_inputs();

    // Multicycle op with mc_start held through the whole op.
    id_ex_mc_start = 1;
    repeat (MC) step();
    id_ex_mc_start = 0;
    step(); step();

    // Reset asserted during cycle 2 of a multicycle op.
    id_ex_mc_start = 1;
    step();
    reset = 1;
    step();
    reset = 0; id_ex_mc_start = 0;
    step(); step();

    // Multicycle op and load-use together: the multicycle op wins.
    id_ex_mc_start = 1; id_ex_mem_read = 1; id_ex_rt = 3; if_id_rt = 3;
    repeat (MC) step();
    idle_inputs();
    step();

    // Random traffic with small register numbers to provoke matches.
    for (int i = 0; i < 400; i++) begin
      reset            = ($urandom_range(0, 60) == 0);
      if_id_rs         = 5'($urandom_range(0, 3));
      if_id_rt         = 5'($urandom_range(0, 3));
      id_ex_rs         = 5'($urandom_range(0, 3));
      id_ex_rt         = 5'($urandom_range(0, 3));
      ex_mem_rd        = 5'($urandom_range(0, 3));
      mem_wb_rd        = 5'($urandom_range(0, 3));
      ex_mem_reg_write = 1'($urandom_range(0, 1));
      mem_wb_reg_write = 1'($urandom_range(0, 1));
      id_ex_mem_read   = ($urandom_range(0, 2) == 0);
      id_ex_mc_start   = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_inputs();
    step();

    @(negedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
